// File: rtl/tt_um_alu_seq.sv
// Sequenced 4-bit ALU: an 8-entry program of {opcode, B} steps is loaded one
// entry per wr strobe, then run against an accumulator seeded on start.
module tt_um_alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] mem [8];
    logic [2:0] wptr;
    logic [3:0] count;
    logic [2:0] pc;
    logic [3:0] acc;
    logic       carry;
    logic       done;

    logic       wr;
    logic       start;
    logic       clr;
    logic       unused_uio;

    logic       do_wr;
    logic       do_start;
    logic       do_clr;
    logic       do_exec;
    logic       last;
    logic [3:0] instr;
    logic [4:0] alu_res;

    assign wr         = uio_in[0];
    assign start      = uio_in[1];
    assign clr        = uio_in[2];
    assign unused_uio = ^uio_in[7:3];

    // Result bit 4 is carry (add) or borrow (sub); logic/shift ops clear it.
    function automatic logic [4:0] alu_op(input logic [2:0] op,
                                          input logic [3:0] a,
                                          input logic       b);
        logic [3:0] bx;
        bx     = {3'b000, b};
        alu_op = 5'b0;
        case (op)
            3'b000: alu_op = {1'b0, a} + {1'b0, bx};
            3'b001: alu_op = {1'b0, a} - {1'b0, bx};
            3'b010: alu_op = {1'b0, a & bx};
            3'b011: alu_op = {1'b0, a | bx};
            3'b100: alu_op = {1'b0, a ^ bx};
            3'b101: alu_op = {1'b0, ~a};
            3'b110: alu_op = {1'b0, a[2:0], 1'b0};
            3'b111: alu_op = {2'b00, a[3:1]};
        endcase
    endfunction

    assign instr   = mem[pc];
    assign alu_res = alu_op(instr[3:1], acc, instr[0]);
    assign last    = ({1'b0, pc} == (count - 4'd1));

    // Control strobes are mutually exclusive: clr > start > wr, all ignored in RUN.
    always_comb begin
        state_nxt = state;
        do_wr     = 1'b0;
        do_start  = 1'b0;
        do_clr    = 1'b0;
        do_exec   = 1'b0;
        if (ena) begin
            case (state)
                S_RUN: begin
                    do_exec = 1'b1;
                    if (last) begin
                        state_nxt = S_DONE;
                    end
                end
                default: begin
                    if (clr) begin
                        do_clr    = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (start) begin
                        do_start  = 1'b1;
                        state_nxt = (count != 4'd0) ? S_RUN : S_DONE;
                    end else if (wr && (count != 4'd8)) begin
                        do_wr = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= 3'd0;
            count <= 4'd0;
            pc    <= 3'd0;
            acc   <= 4'd0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (do_clr) begin
            wptr  <= 3'd0;
            count <= 4'd0;
            done  <= 1'b0;
        end else if (do_start) begin
            acc   <= ui_in[3:0];
            carry <= 1'b0;
            pc    <= 3'd0;
            done  <= (count == 4'd0);
        end else if (do_wr) begin
            wptr  <= wptr + 3'd1;
            count <= count + 4'd1;
        end else if (do_exec) begin
            {carry, acc} <= alu_res;
            if (last) begin
                pc   <= 3'd0;
                done <= 1'b1;
            end else begin
                pc <= pc + 3'd1;
            end
        end
    end

    // Program storage is deliberately left out of reset so it survives clr.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= ui_in[7:4];
        end
    end

    assign uo_out  = {done, (state == S_RUN), (acc == 4'd0), carry, acc};
    assign uio_out = {(count == 4'd8), pc, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_alu_seq.sv
// Scoreboard bench for tt_um_alu_seq: directed scenarios plus randomized
// program/run traffic checked against an arithmetic reference model.
module tb_tt_um_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_alu_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         en_cyc = 0;
    int         cur_exp = 0;
    logic       prev_done = 1'b0;

    // Reference model of the program store
    logic [3:0] m_mem [8];
    int         m_cnt;
    int         m_wp;

    always @(posedge clk) begin
        if (rst_n && ena) en_cyc <= en_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Monitor: each rising edge of done completes one run
    always @(negedge clk) begin
        if (uo_out[7] && !prev_done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got uo_out %0h, expected no completion", uo_out);
            end else begin
                mon_e = q.pop_front();
                check("run_uo", uo_out, mon_e.uo);
                check("run_uio", uio_out, mon_e.uio);
                check("run_latency", en_cyc, mon_e.cyc);
            end
        end
        prev_done = uo_out[7];
    end

    task automatic cyc(input logic wr, input logic st, input logic cl, input logic [7:0] ui);
        ui_in  = ui;
        uio_in = {5'($urandom), cl, st, wr};
        @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] op, input logic b);
        if (m_cnt < 8) begin
            m_mem[m_wp] = {op, b};
            m_wp        = (m_wp + 1) % 8;
            m_cnt++;
        end
        cyc(1'b1, 1'b0, 1'b0, {op, b, 4'($urandom)});
    endtask

    task automatic do_clr(input logic wr, input logic st);
        m_cnt = 0;
        m_wp  = 0;
        cyc(wr, st, 1'b1, 8'($urandom));
    endtask

    task automatic do_start(input logic [3:0] init, input logic wr_too, input bit push);
        exp_t e;
        int   a;
        int   c;
        int   r;
        int   op;
        int   b;
        a = init;
        c = 0;
        for (int i = 0; i < m_cnt; i++) begin
            op = m_mem[i][3:1];
            b  = m_mem[i][0];
            case (op)
                0:       r = a + b;
                1:       r = (a - b < 0) ? a - b + 32 : a - b;
                2:       r = a & b;
                3:       r = a | b;
                4:       r = a ^ b;
                5:       r = 15 - a;
                6:       r = (a * 2) % 16;
                default: r = a / 2;
            endcase
            a = r % 16;
            c = (op <= 1) ? r / 16 : 0;
        end
        e.uo    = {1'b1, 1'b0, (a == 0), c[0], 4'(a)};
        e.uio   = (m_cnt == 8) ? 8'h80 : 8'h00;
        e.cyc   = en_cyc + 1 + m_cnt;
        cur_exp = e.cyc;
        if (push) q.push_back(e);
        cyc(wr_too, 1'b1, 1'b0, {3'($urandom), 1'($urandom), init});
    endtask

    // Let the run finish; in random mode pause ena and throw ignored strobes at RUN
    task automatic run_wait(input bit rnd);
        int   i;
        logic en;
        i = 0;
        while (q.size() != 0 && i < 200) begin
            en  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            ena = en;
            if (rnd && (!en || (en_cyc + 1 <= cur_exp)))
                cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            else
                cyc(1'b0, 1'b0, 1'b0, 8'h00);
            i++;
        end
        ena = 1'b1;
        check("run_timeout", q.size(), 0);
        q.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_cnt  = 0;
        m_wp   = 0;
        #3;
        check("reset_uo", uo_out, 8'h20);
        check("reset_uio", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Three ADD B=1 from 0xE
        repeat (3) do_write(3'b000, 1'b1);
        do_start(4'hE, 1'b0, 1'b1);
        run_wait(1'b0);
        check("add_uo", uo_out, 8'h81);

        // SUB B=1 from 0 borrows
        do_clr(1'b0, 1'b0);
        do_write(3'b001, 1'b1);
        do_start(4'h0, 1'b0, 1'b1);
        run_wait(1'b0);
        check("sub_uo", uo_out, 8'h9F);

        // Empty program finishes on the start edge
        do_clr(1'b0, 1'b0);
        do_start(4'h0, 1'b0, 1'b1);
        run_wait(1'b0);
        check("empty_uo", uo_out, 8'hA0);

        // Fill past capacity with NOT
        do_clr(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            do_write(3'b101, 1'b0);
            if (i == 6) check("full_after7", uio_out[7], 1'b0);
            if (i == 7) check("full_after8", uio_out[7], 1'b1);
        end
        check("full_after9", uio_out, 8'h80);
        do_start(4'h5, 1'b0, 1'b1);
        run_wait(1'b0);
        check("not8_uo", uo_out, 8'h85);
        check("not8_uio", uio_out, 8'h80);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_uo", uo_out, 8'h20);
        check("async_rst_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_wp  = 0;

        // Reset in the middle of a three-step run
        repeat (3) do_write(3'b000, 1'b1);
        do_start(4'h3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check("pc_mid_run", uio_out, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_uo", uo_out, 8'h20);
        check("midrun_rst_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_wp  = 0;
        do_start(4'h0, 1'b0, 1'b1);
        run_wait(1'b0);
        check("post_rst_start_uo", uo_out, 8'hA0);

        // Random program loads, clears, frozen cycles and runs
        for (int it = 0; it < 80; it++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k == 0) begin
                do_clr(1'($urandom), 1'($urandom));
            end else if (k <= 5) begin
                do_write(3'($urandom), 1'($urandom));
            end else if (k == 6) begin
                ena = 1'b0;
                cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                ena = 1'b1;
            end else begin
                if (m_cnt == 0) do_clr(1'b0, 1'b0);
                do_start(4'($urandom), 1'($urandom), 1'b1);
                run_wait(1'b1);
            end
        end

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
